// File: rtl/socket_pkg.sv
//==============================================================================
// Module      : socket_pkg
// Description : Shared types and helpers for the socket round-robin arbiter.
//               - arb_state_t : arbiter FSM state encoding
//               - rr_pick     : rotate-priority search over a request vector
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package socket_pkg;

    // Default data word width of the socket stream.
    localparam int DATA_WITH_DEF = 8;

    // Widest request vector the rotate-priority helper supports.
    localparam int c_max_req = 16;
    localparam int c_idx_w   = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic               found;
        logic [c_idx_w-1:0] idx;
    } rr_pick_t;

    // Returns the first set bit of req[n-1:0], searching upward from ptr and
    // wrapping from n-1 back to 0. ptr must be below n.
    function automatic rr_pick_t rr_pick(
        input logic [c_max_req-1:0] req,
        input logic [c_idx_w-1:0]   ptr,
        input int                   n
    );
        rr_pick_t res;
        int       k;
        res = '0;
        for (int i = 0; i < c_max_req; i++) begin
            if ((i < n) && !res.found) begin
                k = int'(ptr) + i;
                if (k >= n) begin
                    k = k - n;
                end
                if (req[k[c_idx_w-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = k[c_idx_w-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_priority_sel.sv
//==============================================================================
// Module      : rr_priority_sel
// Description : Combinational rotate-priority encoder. Finds the first active
//               request at or above the pointer, wrapping N_REQ-1 -> 0.
// Ports       : i_req   [N_REQ]  request vector (1 = requesting)
//               i_ptr   [IDX_W]  highest-priority index this cycle
//               o_idx   [IDX_W]  index of the selected requester
//               o_valid [1]      at least one request is active
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_priority_sel
    import socket_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    logic [c_max_req-1:0] w_req_ext;
    logic [c_idx_w-1:0]   w_ptr_ext;
    rr_pick_t             w_pick;

    // Widen to the helper's fixed interface; unused high requests stay zero
    // and are never visited because the search is bounded by N_REQ.
    always_comb begin
        w_req_ext = c_max_req'(i_req);
        w_ptr_ext = c_idx_w'(i_ptr);
        w_pick    = rr_pick(w_req_ext, w_ptr_ext, N_REQ);
    end

    assign o_idx   = IDX_W'(w_pick.idx);
    assign o_valid = w_pick.found;

endmodule

`default_nettype wire

// File: rtl/socket_rr_arbiter.sv
//==============================================================================
// Module      : socket_rr_arbiter
// Description : Round-robin arbiter sharing one downstream socket among N_REQ
//               upstream socket FIFOs. Grants one requester at a time, reads
//               it in bursts of up to BURST words, pauses while the
//               downstream is almost full and forwards the returned words on
//               a single registered stream.
// Ports       : i_clk      [1]               clock, rising edge
//               i_rst      [1]               reset, asynchronous, active-low
//               i_empty    [N_REQ]           per-requester FIFO empty flag
//               i_data     [N_REQ*DATA_WITH] requester k at [k*DATA_WITH +: DATA_WITH]
//               i_dv       [N_REQ]           per-requester data valid
//               i_full     [1]               downstream almost-full
//               o_rd_en    [N_REQ]           per-requester read enable (one-hot or zero)
//               o_data     [DATA_WITH]       arbitrated data word, registered
//               o_dv       [1]               o_data valid / downstream write enable
//               o_grant    [$clog2(N_REQ)]   current or last granted requester
//               o_busy     [1]               high while in GRANT
//               o_word_cnt [N_REQ*16]        per-requester forwarded-word counters
//                                            (only with SOCKET_ARB_STATS_EN)
// Build macro : SOCKET_ARB_STATS_EN - adds o_word_cnt and its counters
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module socket_rr_arbiter
    import socket_pkg::*;
#(
    parameter int DATA_WITH = DATA_WITH_DEF,
    parameter int N_REQ     = 4,
    parameter int BURST     = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [N_REQ-1:0]           i_empty,
    input  logic [N_REQ*DATA_WITH-1:0] i_data,
    input  logic [N_REQ-1:0]           i_dv,
    input  logic                       i_full,
    output logic [N_REQ-1:0]           o_rd_en,
    output logic [DATA_WITH-1:0]       o_data,
    output logic                       o_dv,
    output logic [$clog2(N_REQ)-1:0]   o_grant,
    output logic                       o_busy
`ifdef SOCKET_ARB_STATS_EN
    ,
    output logic [N_REQ*16-1:0]        o_word_cnt
`endif
);

    localparam int c_gw = $clog2(N_REQ);
    localparam int c_cw = $clog2(BURST + 1);

    localparam logic [c_cw-1:0] c_burst    = c_cw'(BURST);
    localparam logic [c_cw-1:0] c_burst_m1 = c_cw'(BURST - 1);
    localparam logic [c_gw-1:0] c_last_req = c_gw'(N_REQ - 1);

    //--------------------------------------------------------------------------
    // State
    //--------------------------------------------------------------------------
    arb_state_t            r_state;
    logic [c_gw-1:0]       r_ptr;
    logic [c_gw-1:0]       r_grant;
    logic [c_cw-1:0]       r_cnt;

    logic [c_gw-1:0]       r_grant_d;
    logic                  r_rd_d;
    logic [DATA_WITH-1:0]  r_data;
    logic                  r_dv;

    //--------------------------------------------------------------------------
    // Arbitration
    //--------------------------------------------------------------------------
    logic [c_gw-1:0]       w_sel_idx;
    logic                  w_sel_valid;
    logic                  w_rd;
    logic                  w_last_rd;
    logic                  w_exit;
    logic [c_gw-1:0]       w_ptr_next;
    logic [DATA_WITH-1:0]  w_mux_data;
    logic                  w_mux_dv;

    rr_priority_sel #(
        .N_REQ (N_REQ),
        .IDX_W (c_gw)
    ) u_sel (
        .i_req   (~i_empty),
        .i_ptr   (r_ptr),
        .o_idx   (w_sel_idx),
        .o_valid (w_sel_valid)
    );

    assign w_rd = (r_state == GRANT) && !i_empty[r_grant] && !i_full
                  && (r_cnt < c_burst);

    // Leaving on the read that fills the burst (rather than one cycle later)
    // keeps a back-to-back burst at BURST reads plus one arbitration cycle.
    assign w_last_rd = w_rd && (r_cnt == c_burst_m1);

    assign w_exit = (r_state == GRANT)
                    && ((!i_full && i_empty[r_grant])
                        || (r_cnt >= c_burst)
                        || w_last_rd);

    assign w_ptr_next = (r_grant == c_last_req) ? '0 : r_grant + 1'b1;

    always_comb begin
        o_rd_en = '0;
        if (w_rd) begin
            o_rd_en[r_grant] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_sel_valid) begin
                        r_grant <= w_sel_idx;
                        r_cnt   <= '0;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_rd) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (w_exit) begin
                        r_state <= IDLE;
                        r_ptr   <= w_ptr_next;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Output path
    //--------------------------------------------------------------------------
    // The word answering a read arrives one cycle later, so the source is
    // selected with the grant delayed by one cycle. Qualifying with the
    // delayed read strobe drops data-valid pulses that do not answer a read
    // issued since reset, so nothing in flight survives a reset.
    assign w_mux_data = i_data[int'(r_grant_d) * DATA_WITH +: DATA_WITH];
    assign w_mux_dv   = r_rd_d && i_dv[r_grant_d];

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_grant_d <= '0;
            r_rd_d    <= 1'b0;
            r_data    <= '0;
            r_dv      <= 1'b0;
        end else begin
            r_grant_d <= r_grant;
            r_rd_d    <= w_rd;
            r_dv      <= w_mux_dv;
            if (w_mux_dv) begin
                r_data <= w_mux_data;
            end
        end
    end

    assign o_data  = r_data;
    assign o_dv    = r_dv;
    assign o_grant = r_grant;
    assign o_busy  = (r_state == GRANT);

    //--------------------------------------------------------------------------
    // Optional forwarded-word statistics
    //--------------------------------------------------------------------------
`ifdef SOCKET_ARB_STATS_EN
    for (genvar k = 0; k < N_REQ; k++) begin : g_stats
        logic [15:0] r_word_cnt;

        // Counts on the same edge that registers the word into o_data;
        // wraps naturally from 0xFFFF to 0.
        always_ff @(posedge i_clk or negedge i_rst) begin
            if (!i_rst) begin
                r_word_cnt <= '0;
            end else if (w_mux_dv && (r_grant_d == c_gw'(k))) begin
                r_word_cnt <= r_word_cnt + 16'd1;
            end
        end

        assign o_word_cnt[k*16 +: 16] = r_word_cnt;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_socket_rr_arbiter.sv
//==============================================================================
// Module      : tb_socket_rr_arbiter
// Description : Self-checking bench for socket_rr_arbiter with four FIFO
//               models (one-cycle read latency) and an in-order scoreboard
//               of expected output words.
// Build macro : SOCKET_ARB_STATS_EN - also exercises o_word_cnt
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_socket_rr_arbiter;

    localparam int DATA_WITH = 8;
    localparam int N_REQ     = 4;
    localparam int BURST     = 4;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic [N_REQ-1:0]           empty;
    logic [N_REQ*DATA_WITH-1:0] fifo_data = '0;
    logic [N_REQ-1:0]           fifo_dv   = '0;
    logic                       full;
    logic [N_REQ-1:0]           rd_en;
    logic [DATA_WITH-1:0]       odata;
    logic                       odv;
    logic [1:0]                 grant;
    logic                       busy;
`ifdef SOCKET_ARB_STATS_EN
    logic [N_REQ*16-1:0]        word_cnt;
`endif

    socket_rr_arbiter #(
        .DATA_WITH (DATA_WITH),
        .N_REQ     (N_REQ),
        .BURST     (BURST)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst_n),
        .i_empty    (empty),
        .i_data     (fifo_data),
        .i_dv       (fifo_dv),
        .i_full     (full),
        .o_rd_en    (rd_en),
        .o_data     (odata),
        .o_dv       (odv),
        .o_grant    (grant),
        .o_busy     (busy)
`ifdef SOCKET_ARB_STATS_EN
        ,
        .o_word_cnt (word_cnt)
`endif
    );

    always #5 clk = ~clk;

    //--------------------------------------------------------------------------
    // FIFO models: entry n of requester k carries {k, n[5:0]}
    //--------------------------------------------------------------------------
    int unsigned push_total [N_REQ];
    int unsigned pop_total  [N_REQ];
    logic        underflow = 1'b0;

    function automatic logic [7:0] word_of(input int k, input int unsigned n);
        return {2'(k), 6'(n)};
    endfunction

    always_comb begin
        empty = '0;
        for (int k = 0; k < N_REQ; k++) begin
            empty[k] = (push_total[k] == pop_total[k]);
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < N_REQ; k++) begin
            if (rd_en[k]) begin
                if (push_total[k] == pop_total[k]) begin
                    underflow <= 1'b1;
                end
                pop_total[k] <= pop_total[k] + 1;
                fifo_data[k*DATA_WITH +: DATA_WITH] <= word_of(k, pop_total[k]);
                fifo_dv[k] <= 1'b1;
            end else begin
                fifo_dv[k] <= 1'b0;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Checking helpers
    //--------------------------------------------------------------------------
    int               n_assert = 0;
    int               n_fail   = 0;
    logic [7:0]       sb_q [$];
    logic [N_REQ-1:0] rd_seen;
    logic             busy_seen;
    logic             prev_rd   = 1'b0;
    logic [7:0]       last_data = '0;
    bit               chk_on    = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Samples rd_en/busy just before the coming rising edge, then checks the
    // output stream on the following falling edge.
    task automatic cyc();
        logic [7:0] exp;
        #1;
        rd_seen   = rd_en;
        busy_seen = busy;
        @(negedge clk);
        if (chk_on) begin
            check("latency_dv", {31'd0, odv}, {31'd0, prev_rd});
            if (odv) begin
                check("sb_has_entry", {31'd0, sb_q.size() != 0}, 32'd1);
                if (sb_q.size() != 0) begin
                    exp = sb_q.pop_front();
                    check("sb_data", {24'd0, odata}, {24'd0, exp});
                    last_data = exp;
                end
            end else begin
                check("hold_data", {24'd0, odata}, {24'd0, last_data});
            end
        end
        prev_rd = |rd_seen;
    endtask

    task automatic step(input string tag, input logic [N_REQ-1:0] exp_rd, input logic exp_busy);
        cyc();
        check({tag, "_rd"}, {28'd0, rd_seen}, {28'd0, exp_rd});
        check({tag, "_busy"}, {31'd0, busy_seen}, {31'd0, exp_busy});
    endtask

    task automatic load(input int k, input int n, input bit push_exp);
        for (int j = 0; j < n; j++) begin
            if (push_exp) begin
                sb_q.push_back(word_of(k, push_total[k] + j));
            end
        end
        push_total[k] = push_total[k] + n;
    endtask

    task automatic do_reset();
        chk_on = 1'b0;
        rst_n  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            push_total[k] = pop_total[k];
        end
        cyc();
        cyc();
        rst_n     = 1'b1;
        sb_q.delete();
        last_data = '0;
        prev_rd   = 1'b0;
        chk_on    = 1'b1;
    endtask

    //--------------------------------------------------------------------------
    // Directed sequence
    //--------------------------------------------------------------------------
    initial begin
        int unsigned base [N_REQ];
        rst_n = 1'b0;
        full  = 1'b0;
        repeat (2) @(negedge clk);

        // 1. Reset
        check("rst_rd_en", {28'd0, rd_en}, 32'd0);
        check("rst_data",  {24'd0, odata}, 32'd0);
        check("rst_dv",    {31'd0, odv},   32'd0);
        check("rst_grant", {30'd0, grant}, 32'd0);
        check("rst_busy",  {31'd0, busy},  32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < N_REQ; k++) load(k, 8, 1'b0);
        cyc();
        check("t1_idle_rd", {28'd0, rd_seen}, 32'd0);
        cyc();
        check("t1_burst_rd", {28'd0, rd_seen}, 32'd1);
        // Short reset pulse while the word for that read is in flight.
        rst_n = 1'b0;
        #2;
        check("t1_mid_rd_en", {28'd0, rd_en}, 32'd0);
        check("t1_mid_dv",    {31'd0, odv},   32'd0);
        check("t1_mid_data",  {24'd0, odata}, 32'd0);
        check("t1_mid_busy",  {31'd0, busy},  32'd0);
        rst_n = 1'b1;
        cyc();
        check("t1_post_dv0", {31'd0, odv}, 32'd0);
        cyc();
        check("t1_post_dv1", {31'd0, odv}, 32'd0);
        do_reset();

        // 2. Single requester, 3 words
        load(2, 3, 1'b1);
        step("t2_arb", 4'b0000, 1'b0);
        step("t2_r0",  4'b0100, 1'b1);
        step("t2_r1",  4'b0100, 1'b1);
        step("t2_r2",  4'b0100, 1'b1);
        step("t2_ex",  4'b0000, 1'b1);
        step("t2_idl", 4'b0000, 1'b0);
        check("t2_grant", {30'd0, grant}, 32'd2);
        step("t2_idl2", 4'b0000, 1'b0);
        check("t2_drained", sb_q.size(), 32'd0);

        // 3. Round-robin, all four FIFOs with 8 words
        do_reset();
        for (int k = 0; k < N_REQ; k++) base[k] = push_total[k];
        for (int g = 0; g < 8; g++) begin
            for (int j = 0; j < BURST; j++) begin
                sb_q.push_back(word_of(g % 4, base[g % 4] + (g / 4) * 4 + j));
            end
        end
        for (int k = 0; k < N_REQ; k++) push_total[k] = push_total[k] + 8;
        for (int g = 0; g < 8; g++) begin
            step("t3_arb", 4'b0000, 1'b0);
            for (int j = 0; j < BURST; j++) begin
                step("t3_rd", 4'(1 << (g % 4)), 1'b1);
            end
        end
        step("t3_idl", 4'b0000, 1'b0);
        step("t3_idl", 4'b0000, 1'b0);
        check("t3_grant", {30'd0, grant}, 32'd3);
        check("t3_drained", sb_q.size(), 32'd0);

        // 4. Backpressure mid-burst
        load(0, 4, 1'b1);
        step("t4_arb", 4'b0000, 1'b0);
        step("t4_r0",  4'b0001, 1'b1);
        step("t4_r1",  4'b0001, 1'b1);
        full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step("t4_stall", 4'b0000, 1'b1);
            check("t4_stall_grant", {30'd0, grant}, 32'd0);
        end
        full = 1'b0;
        step("t4_r2",  4'b0001, 1'b1);
        step("t4_r3",  4'b0001, 1'b1);
        step("t4_idl", 4'b0000, 1'b0);
        step("t4_idl", 4'b0000, 1'b0);
        check("t4_drained", sb_q.size(), 32'd0);

        // 5. Wrap and skip from pointer 1
        load(3, 2, 1'b1);
        load(0, 2, 1'b1);
        step("t5_arb3", 4'b0000, 1'b0);
        step("t5_r3",   4'b1000, 1'b1);
        step("t5_r3",   4'b1000, 1'b1);
        step("t5_ex3",  4'b0000, 1'b1);
        step("t5_arb0", 4'b0000, 1'b0);
        step("t5_r0",   4'b0001, 1'b1);
        step("t5_r0",   4'b0001, 1'b1);
        step("t5_ex0",  4'b0000, 1'b1);
        step("t5_idl",  4'b0000, 1'b0);
        // Pointer now at 1: req2 must beat req0.
        load(2, 1, 1'b1);
        load(0, 1, 1'b1);
        step("t5_arb2", 4'b0000, 1'b0);
        step("t5_r2",   4'b0100, 1'b1);
        step("t5_ex2",  4'b0000, 1'b1);
        step("t5_arb0b", 4'b0000, 1'b0);
        step("t5_r0b",  4'b0001, 1'b1);
        step("t5_ex0b", 4'b0000, 1'b1);
        step("t5_idl",  4'b0000, 1'b0);
        step("t5_idl",  4'b0000, 1'b0);
        check("t5_drained", sb_q.size(), 32'd0);

`ifdef SOCKET_ARB_STATS_EN
        // 6. Statistics counter wrap
        do_reset();
        load(1, 65537, 1'b1);
        for (int i = 0; i < 90000 && sb_q.size() != 0; i++) begin
            cyc();
        end
        check("t6_drained", sb_q.size(), 32'd0);
        check("t6_cnt0", {16'd0, word_cnt[0  +: 16]}, 32'd0);
        check("t6_cnt1", {16'd0, word_cnt[16 +: 16]}, 32'd1);
        check("t6_cnt2", {16'd0, word_cnt[32 +: 16]}, 32'd0);
        check("t6_cnt3", {16'd0, word_cnt[48 +: 16]}, 32'd0);
`endif

        check("no_underflow", {31'd0, underflow}, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
